// File: rtl/videosyncs_prog.sv
// ----------------------------------------------------------------------------
// videosyncs_prog
//
// Runtime-programmable VGA/VESA sync generator. Free-running pixel (hc) and
// scan (vc) counters are decoded against an "active" mode register set to
// produce hs, vs, display_enable and line/frame strobes. A new mode is loaded
// through a valid/ready handshake into a "pending" set. It is validated when
// it is captured, and it is applied only at the last pixel of a frame, so the
// first pixel of the next frame already uses the new mode. A parametrised
// delay line aligns the decoded outputs with a downstream pixel pipeline.
//
// Optional feature: define VIDEOSYNCS_PROG_FIELD_CNT_EN to add frame_count,
// a 16-bit count of frame wraps that is aligned with frame_start.
//
// Ports
//   clk, rst_n                   pixel clock, asynchronous active-low reset
//   cfg_valid / cfg_ready        mode load handshake
//   cfg_h*/cfg_v*                horizontal / vertical timing fields (CW bits)
//   cfg_hpol, cfg_vpol           sync polarity (1 = positive pulse)
//   cfg_err                      one-cycle pulse when a captured mode is illegal
//   hc, vc                       raw counters (zero latency)
//   hs, vs, display_enable       decoded video timing (1+PIPE_DELAY latency)
//   line_start, frame_start      one-cycle strobes (1+PIPE_DELAY latency)
//   mode_applied                 pulses with the first hc=vc=0 of a new mode
//   frame_count                  (optional) frame wrap counter
// ----------------------------------------------------------------------------
module videosyncs_prog #(
    parameter int   CW             = 12,
    parameter int   PIPE_DELAY     = 0,
    parameter int   DEF_HACTIVE    = 640,
    parameter int   DEF_HSYNCSTART = 656,
    parameter int   DEF_HSYNCEND   = 752,
    parameter int   DEF_HTOTAL     = 800,
    parameter int   DEF_VACTIVE    = 480,
    parameter int   DEF_VSYNCSTART = 490,
    parameter int   DEF_VSYNCEND   = 492,
    parameter int   DEF_VTOTAL     = 525,
    parameter logic DEF_HPOL       = 1'b0,
    parameter logic DEF_VPOL       = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_hactive,
    input  logic [CW-1:0] cfg_hsyncstart,
    input  logic [CW-1:0] cfg_hsyncend,
    input  logic [CW-1:0] cfg_htotal,
    input  logic [CW-1:0] cfg_vactive,
    input  logic [CW-1:0] cfg_vsyncstart,
    input  logic [CW-1:0] cfg_vsyncend,
    input  logic [CW-1:0] cfg_vtotal,
    input  logic          cfg_hpol,
    input  logic          cfg_vpol,
    output logic          cfg_err,
    output logic [CW-1:0] hc,
    output logic [CW-1:0] vc,
    output logic          hs,
    output logic          vs,
    output logic          display_enable,
    output logic          line_start,
    output logic          frame_start,
    output logic          mode_applied
`ifdef VIDEOSYNCS_PROG_FIELD_CNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    typedef struct packed {
        logic [CW-1:0] hactive;
        logic [CW-1:0] hsyncstart;
        logic [CW-1:0] hsyncend;
        logic [CW-1:0] htotal;
        logic [CW-1:0] vactive;
        logic [CW-1:0] vsyncstart;
        logic [CW-1:0] vsyncend;
        logic [CW-1:0] vtotal;
        logic          hpol;
        logic          vpol;
    } mode_t;

    // One record per delay stage: everything that must stay aligned.
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
`ifdef VIDEOSYNCS_PROG_FIELD_CNT_EN
        logic [15:0] fc;
`endif
    } sync_t;

    localparam mode_t DEF_MODE = '{
        hactive:    CW'(DEF_HACTIVE),
        hsyncstart: CW'(DEF_HSYNCSTART),
        hsyncend:   CW'(DEF_HSYNCEND),
        htotal:     CW'(DEF_HTOTAL),
        vactive:    CW'(DEF_VACTIVE),
        vsyncstart: CW'(DEF_VSYNCSTART),
        vsyncend:   CW'(DEF_VSYNCEND),
        vtotal:     CW'(DEF_VTOTAL),
        hpol:       DEF_HPOL,
        vpol:       DEF_VPOL
    };

    // Inactive output levels: syncs deasserted, strobes and enable low.
    localparam sync_t SYNC_IDLE = '{hs: ~DEF_HPOL, vs: ~DEF_VPOL, default: '0};

    // A legal axis satisfies 0 < active <= syncstart < syncend <= total, total >= 2.
    function automatic logic axis_legal(input logic [CW-1:0] act, input logic [CW-1:0] ss,
                                        input logic [CW-1:0] se,  input logic [CW-1:0] tot);
        return (act != '0) && (act <= ss) && (ss < se) && (se <= tot) && (tot >= CW'(2));
    endfunction

    mode_t         active_mode;
    mode_t         pending_mode;
    mode_t         cfg_mode;
    logic          pending_valid;
    logic [CW-1:0] hc_q;
    logic [CW-1:0] vc_q;
    logic          mode_legal;
    logic          capture;
    logic          h_last;
    logic          v_last;
    logic          frame_last;
    logic          apply;
    sync_t         dec;
    sync_t         pipe [0:PIPE_DELAY];
`ifdef VIDEOSYNCS_PROG_FIELD_CNT_EN
    logic [15:0]   fc_q;
`endif

    assign cfg_mode = '{
        hactive:    cfg_hactive,
        hsyncstart: cfg_hsyncstart,
        hsyncend:   cfg_hsyncend,
        htotal:     cfg_htotal,
        vactive:    cfg_vactive,
        vsyncstart: cfg_vsyncstart,
        vsyncend:   cfg_vsyncend,
        vtotal:     cfg_vtotal,
        hpol:       cfg_hpol,
        vpol:       cfg_vpol
    };

    assign mode_legal = axis_legal(cfg_hactive, cfg_hsyncstart, cfg_hsyncend, cfg_htotal) &&
                        axis_legal(cfg_vactive, cfg_vsyncstart, cfg_vsyncend, cfg_vtotal);

    // Ready is low while a mode waits, so capture and apply never coincide.
    assign cfg_ready  = !pending_valid;
    assign capture    = cfg_valid && !pending_valid;
    assign h_last     = (hc_q == active_mode.htotal - CW'(1));
    assign v_last     = (vc_q == active_mode.vtotal - CW'(1));
    assign frame_last = h_last && v_last;
    assign apply      = frame_last && pending_valid;

    // Counters, active mode and handshake state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q          <= '0;
            vc_q          <= '0;
            active_mode   <= DEF_MODE;
            pending_valid <= 1'b0;
            cfg_err       <= 1'b0;
            mode_applied  <= 1'b0;
`ifdef VIDEOSYNCS_PROG_FIELD_CNT_EN
            fc_q          <= '0;
`endif
        end else begin
            cfg_err      <= capture && !mode_legal;
            // Registered so the pulse lands with the first hc=vc=0 of the new mode.
            mode_applied <= apply;

            if (apply) begin
                active_mode   <= pending_mode;
                pending_valid <= 1'b0;
            end else if (capture && mode_legal) begin
                pending_valid <= 1'b1;
            end

            // Wrap decisions use the outgoing mode; the apply cycle is always
            // a full frame wrap, so the new mode starts cleanly at 0,0.
            if (h_last) begin
                hc_q <= '0;
                vc_q <= v_last ? '0 : vc_q + CW'(1);
            end else begin
                hc_q <= hc_q + CW'(1);
            end

`ifdef VIDEOSYNCS_PROG_FIELD_CNT_EN
            if (frame_last) begin
                fc_q <= fc_q + 16'd1;
            end
`endif
        end
    end

    // NOTE: pending_mode is qualified by pending_valid, so the data register
    // needs no reset; only the flag that guards it is reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            pending_mode <= cfg_mode;
        end
    end

    // Decode of the current counters against the active mode.
    always_comb begin
        dec    = SYNC_IDLE;
        dec.hs = ((hc_q >= active_mode.hsyncstart) && (hc_q < active_mode.hsyncend))
                 ? active_mode.hpol : ~active_mode.hpol;
        dec.vs = ((vc_q >= active_mode.vsyncstart) && (vc_q < active_mode.vsyncend))
                 ? active_mode.vpol : ~active_mode.vpol;
        dec.de = (hc_q < active_mode.hactive) && (vc_q < active_mode.vactive);
        dec.ls = (hc_q == '0);
        dec.fs = (hc_q == '0) && (vc_q == '0);
`ifdef VIDEOSYNCS_PROG_FIELD_CNT_EN
        dec.fc = fc_q;
`endif
    end

    // Stage 0 is the mandatory decode register; stages 1..PIPE_DELAY are the
    // alignment delay line. All stages reset to the inactive levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= PIPE_DELAY; i++) begin
                pipe[i] <= SYNC_IDLE;
            end
        end else begin
            pipe[0] <= dec;
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign hc             = hc_q;
    assign vc             = vc_q;
    assign hs             = pipe[PIPE_DELAY].hs;
    assign vs             = pipe[PIPE_DELAY].vs;
    assign display_enable = pipe[PIPE_DELAY].de;
    assign line_start     = pipe[PIPE_DELAY].ls;
    assign frame_start    = pipe[PIPE_DELAY].fs;
`ifdef VIDEOSYNCS_PROG_FIELD_CNT_EN
    assign frame_count    = pipe[PIPE_DELAY].fc;
`endif

endmodule

// File: tb/tb_videosyncs_prog.sv
// ----------------------------------------------------------------------------
// tb_videosyncs_prog
//
// Three instances share clock and reset:
//   dut_vga : stock 640x480 defaults, checked over its first line from a table.
//   dut0    : small default mode (24x10 frame), PIPE_DELAY=0.
//   dut3    : same as dut0 with PIPE_DELAY=3, sharing dut0's cfg inputs.
// A behavioural model of counters, mode registers and handshake pushes one
// expected decode record per clock into two queues; each queue is popped once
// its depth exceeds the instance's delay, so dut3 is held to dut0's stream
// shifted by exactly three cycles, including across mode switches and reset.
// ----------------------------------------------------------------------------
module tb_videosyncs_prog;

    localparam int CW = 12;

    typedef struct packed {
        logic [CW-1:0] ha, hss, hse, ht, va, vss, vse, vt;
        logic          hp, vp;
    } mode_t;

    typedef struct packed {
        logic        hs, vs, de, ls, fs;
        logic [15:0] fc;
    } sync_e;

    // Small default mode keeps whole frames cheap to simulate.
    localparam mode_t SMALL_DEF = '{ha: 16, hss: 18, hse: 22, ht: 24,
                                    va: 6,  vss: 7,  vse: 8,  vt: 10, hp: 1'b0, vp: 1'b0};
    localparam mode_t MODE_A    = '{ha: 20, hss: 21, hse: 24, ht: 26,
                                    va: 6,  vss: 7,  vse: 8,  vt: 9,  hp: 1'b1, vp: 1'b1};
    localparam mode_t MODE_B    = '{ha: 12, hss: 13, hse: 15, ht: 17,
                                    va: 4,  vss: 5,  vse: 6,  vt: 7,  hp: 1'b0, vp: 1'b0};
    localparam mode_t MODE_BAD  = '{ha: 20, hss: 22, hse: 22, ht: 26,
                                    va: 6,  vss: 7,  vse: 8,  vt: 9,  hp: 1'b1, vp: 1'b1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_valid = 1'b0;
    logic vga_valid = 1'b0;
    mode_t cfg = SMALL_DEF;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // ------------------------------------------------------------------ DUTs
    logic          rdy0, err0, hs0, vs0, de0, ls0, fs0, ap0;
    logic [CW-1:0] hc0, vc0;
    logic          rdy3, err3, hs3, vs3, de3, ls3, fs3, ap3;
    logic [CW-1:0] hc3, vc3;
    logic          rdyv, errv, hsv, vsv, dev, lsv, fsv, apv;
    logic [CW-1:0] hcv, vcv;
`ifdef VIDEOSYNCS_PROG_FIELD_CNT_EN
    logic [15:0]   fc0, fc3, fcv;
`endif

    videosyncs_prog #(
        .CW(CW), .PIPE_DELAY(0),
        .DEF_HACTIVE(16), .DEF_HSYNCSTART(18), .DEF_HSYNCEND(22), .DEF_HTOTAL(24),
        .DEF_VACTIVE(6),  .DEF_VSYNCSTART(7),  .DEF_VSYNCEND(8),  .DEF_VTOTAL(10),
        .DEF_HPOL(1'b0),  .DEF_VPOL(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(rdy0),
        .cfg_hactive(cfg.ha), .cfg_hsyncstart(cfg.hss), .cfg_hsyncend(cfg.hse), .cfg_htotal(cfg.ht),
        .cfg_vactive(cfg.va), .cfg_vsyncstart(cfg.vss), .cfg_vsyncend(cfg.vse), .cfg_vtotal(cfg.vt),
        .cfg_hpol(cfg.hp), .cfg_vpol(cfg.vp), .cfg_err(err0), .hc(hc0), .vc(vc0),
        .hs(hs0), .vs(vs0), .display_enable(de0), .line_start(ls0), .frame_start(fs0),
`ifdef VIDEOSYNCS_PROG_FIELD_CNT_EN
        .frame_count(fc0),
`endif
        .mode_applied(ap0)
    );

    videosyncs_prog #(
        .CW(CW), .PIPE_DELAY(3),
        .DEF_HACTIVE(16), .DEF_HSYNCSTART(18), .DEF_HSYNCEND(22), .DEF_HTOTAL(24),
        .DEF_VACTIVE(6),  .DEF_VSYNCSTART(7),  .DEF_VSYNCEND(8),  .DEF_VTOTAL(10),
        .DEF_HPOL(1'b0),  .DEF_VPOL(1'b0)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(rdy3),
        .cfg_hactive(cfg.ha), .cfg_hsyncstart(cfg.hss), .cfg_hsyncend(cfg.hse), .cfg_htotal(cfg.ht),
        .cfg_vactive(cfg.va), .cfg_vsyncstart(cfg.vss), .cfg_vsyncend(cfg.vse), .cfg_vtotal(cfg.vt),
        .cfg_hpol(cfg.hp), .cfg_vpol(cfg.vp), .cfg_err(err3), .hc(hc3), .vc(vc3),
        .hs(hs3), .vs(vs3), .display_enable(de3), .line_start(ls3), .frame_start(fs3),
`ifdef VIDEOSYNCS_PROG_FIELD_CNT_EN
        .frame_count(fc3),
`endif
        .mode_applied(ap3)
    );

    videosyncs_prog #(.CW(CW)) dut_vga (
        .clk(clk), .rst_n(rst_n), .cfg_valid(vga_valid), .cfg_ready(rdyv),
        .cfg_hactive(cfg.ha), .cfg_hsyncstart(cfg.hss), .cfg_hsyncend(cfg.hse), .cfg_htotal(cfg.ht),
        .cfg_vactive(cfg.va), .cfg_vsyncstart(cfg.vss), .cfg_vsyncend(cfg.vse), .cfg_vtotal(cfg.vt),
        .cfg_hpol(cfg.hp), .cfg_vpol(cfg.vp), .cfg_err(errv), .hc(hcv), .vc(vcv),
        .hs(hsv), .vs(vsv), .display_enable(dev), .line_start(lsv), .frame_start(fsv),
`ifdef VIDEOSYNCS_PROG_FIELD_CNT_EN
        .frame_count(fcv),
`endif
        .mode_applied(apv)
    );

    // ------------------------------------------------------------ checking
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    localparam sync_e IDLE_E = '{hs: 1'b1, vs: 1'b1, default: '0};

    mode_t       m_act, m_pend;
    logic        m_pv, m_err, m_applied;
    logic [CW-1:0] m_hc, m_vc;
    logic [15:0] m_fc;
    sync_e       q0[$];
    sync_e       q3[$];

    function automatic logic axis_ok(input int a, input int s, input int e, input int t);
        return a > 0 && a <= s && s < e && e <= t && t >= 2;
    endfunction

    function automatic sync_e model_decode(input int h, input int v, input mode_t m, input logic [15:0] fc);
        sync_e r;
        r.hs = (h >= int'(m.hss) && h < int'(m.hse)) ? m.hp : !m.hp;
        r.vs = (v >= int'(m.vss) && v < int'(m.vse)) ? m.vp : !m.vp;
        r.de = (h < int'(m.ha)) && (v < int'(m.va));
        r.ls = (h == 0);
        r.fs = (h == 0) && (v == 0);
        r.fc = fc;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = SMALL_DEF; m_pv = 1'b0; m_err = 1'b0; m_applied = 1'b0;
            m_hc = '0; m_vc = '0; m_fc = '0;
            q0.delete(); q3.delete();
        end else begin
            logic cap, legal, last;
            q0.push_back(model_decode(int'(m_hc), int'(m_vc), m_act, m_fc));
            q3.push_back(model_decode(int'(m_hc), int'(m_vc), m_act, m_fc));
            cap   = cfg_valid && !m_pv;
            legal = axis_ok(cfg.ha, cfg.hss, cfg.hse, cfg.ht) && axis_ok(cfg.va, cfg.vss, cfg.vse, cfg.vt);
            last  = (int'(m_hc) == int'(m_act.ht) - 1) && (int'(m_vc) == int'(m_act.vt) - 1);
            m_err     = cap && !legal;
            m_applied = last && m_pv;
            if (int'(m_hc) == int'(m_act.ht) - 1) begin
                m_hc = '0;
                m_vc = (int'(m_vc) == int'(m_act.vt) - 1) ? '0 : m_vc + 1'b1;
            end else begin
                m_hc = m_hc + 1'b1;
            end
            if (last) m_fc = m_fc + 16'd1;
            if (m_applied) begin m_act = m_pend; m_pv = 1'b0; end
            if (cap && legal) begin m_pend = cfg; m_pv = 1'b1; end
        end
    end

    // Every cycle: counters and handshake against the model, decoded outputs
    // against the scoreboard queues.
    always @(negedge clk) begin
        sync_e e0, e3;
        e0 = (q0.size() > 0) ? q0.pop_front() : IDLE_E;
        e3 = (q3.size() > 3) ? q3.pop_front() : IDLE_E;
        check("d0_ctrl", {hc0, vc0, rdy0, err0, ap0}, {m_hc, m_vc, !m_pv, m_err, m_applied});
        check("d3_ctrl", {hc3, vc3, rdy3, err3, ap3}, {m_hc, m_vc, !m_pv, m_err, m_applied});
        check("d0_sync", {27'd0, hs0, vs0, de0, ls0, fs0}, {27'd0, e0.hs, e0.vs, e0.de, e0.ls, e0.fs});
        check("d3_sync", {27'd0, hs3, vs3, de3, ls3, fs3}, {27'd0, e3.hs, e3.vs, e3.de, e3.ls, e3.fs});
`ifdef VIDEOSYNCS_PROG_FIELD_CNT_EN
        check("d0_fcnt", {16'd0, fc0}, {16'd0, e0.fc});
        check("d3_fcnt", {16'd0, fc3}, {16'd0, e3.fc});
`endif
    end

    // ------------------------------------------------------------ stimulus
    typedef struct {
        int   probe_hc;
        logic exp_hs;
        logic exp_vs;
        logic exp_de;
        logic exp_ls;
    } vga_vec_t;

    vga_vec_t vt[9];

    task automatic present(input mode_t m);
        cfg = m;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int cyc, per, de_cnt, hs_cnt, ap_cnt;

        // Stock VGA first line: hs low for hc 656..751, enable for hc < 640,
        // each observed one cycle after the counter value.
        vt[0] = '{2,   1'b1, 1'b1, 1'b1, 1'b0};
        vt[1] = '{639, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[2] = '{640, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[3] = '{655, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4] = '{656, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[5] = '{751, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[6] = '{752, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[7] = '{799, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8] = '{0,   1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_vga_outs", {hsv, vsv, dev, lsv, fsv, rdyv, errv, apv}, 8'b1100_0100);
        check("rst_vga_cnt", {hcv, vcv}, 24'd0);
        rst_n = 1'b1;

        // Table-driven first line of the stock mode.
        foreach (vt[k]) begin
            for (int i = 0; i < 2000 && int'(hcv) != vt[k].probe_hc; i++) @(negedge clk);
            check("vga_probe_reached", hcv, vt[k].probe_hc);
            @(negedge clk);
            check("vga_line0", {hsv, vsv, dev, lsv},
                  {vt[k].exp_hs, vt[k].exp_vs, vt[k].exp_de, vt[k].exp_ls});
        end

        // Mode A loaded mid-frame; current frame completes in the old mode.
        for (int i = 0; i < 1000 && !(hc0 == 12'd5 && vc0 == 12'd2); i++) @(negedge clk);
        check("midframe_reached", {hc0, vc0}, {12'd5, 12'd2});
        present(MODE_A);
        check("ready_drop", rdy0, 1'b0);

        // Mode B held valid while A pends: accepted only after A applies.
        cfg = MODE_B;
        cfg_valid = 1'b1;
        for (int i = 0; i < 1000 && !rdy0; i++) @(negedge clk);
        check("ready_rise", rdy0, 1'b1);
        check("apply_align", {hc0, vc0, ap0}, {12'd0, 12'd0, 1'b1});
        @(negedge clk);
        cfg_valid = 1'b0;
        check("second_capture", rdy0, 1'b0);

        // First frame of mode A: period 26*9, enable 20*6, positive hs 3*9.
        check("modeA_fs", fs0, 1'b1);
        per = 1; de_cnt = int'(de0); hs_cnt = int'(hs0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fs0) break;
            per++; de_cnt += int'(de0); hs_cnt += int'(hs0);
        end
        check("modeA_period", per, 26 * 9);
        check("modeA_de_cycles", de_cnt, 20 * 6);
        check("modeA_hs_high", hs_cnt, 3 * 9);

        // Let mode B run a frame, then an illegal mode: handshake completes,
        // cfg_err pulses once, nothing becomes pending.
        repeat (140) @(negedge clk);
        for (int i = 0; i < 1000 && !rdy0; i++) @(negedge clk);
        present(MODE_BAD);
        check("bad_err_pulse", {err0, rdy0}, 2'b11);
        @(negedge clk);
        check("bad_err_clear", {err0, rdy0}, 2'b01);
        repeat (150) @(negedge clk);

        // Reset mid-line with mode A pending.
        present(MODE_A);
        check("pending_before_rst", rdy0, 1'b0);
        for (int i = 0; i < 1000 && hc0 != 12'd3; i++) @(negedge clk);
        check("rst_point_reached", hc0, 12'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_d0", {hc0, vc0, rdy0, err0, ap0, hs0, vs0, de0, ls0, fs0},
              {12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check("async_rst_d3", {hc3, rdy3, hs3, vs3, de3, fs3}, {12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Defaults run; the lost pending mode must never apply.
        ap_cnt = 0;
        cyc = 0;
        repeat (3 * 240) begin
            @(negedge clk);
            ap_cnt += int'(ap0);
            cyc += int'(fs0);
        end
        check("no_apply_after_rst", ap_cnt, 0);
        check("default_frames_after_rst", cyc, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
